// File: rtl/sampler_pkg.sv
// Shared types and constants for the lease sampler drain controller:
// state encoding, header layout, host word order and sampler comm bit positions.
package sampler_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RUN,
    S_DUMP,
    S_DUMP_WAIT,
    S_HDR,
    S_READ,
    S_WAIT,
    S_EMIT,
    S_CLEAR,
    S_DONE
  } state_e;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned N_WORDS = 5;

  // Host word order for one stored sample
  localparam int unsigned W_INTERVAL = 0;
  localparam int unsigned W_PC       = 1;
  localparam int unsigned W_TRACE_LO = 2;
  localparam int unsigned W_TRACE_HI = 3;
  localparam int unsigned W_TARGET   = 4;

  localparam int unsigned HDR_FINAL_BIT = 31;
  localparam int unsigned HDR_USED_W    = 16;

  // Sampler comm register bit positions
  localparam int unsigned COMM_RUN_BIT   = 24;
  localparam int unsigned COMM_CLEAR_BIT = 23;
  localparam int unsigned COMM_DUMP_BIT  = 22;
  localparam int unsigned COMM_ADDR_MSB  = 16;
  localparam int unsigned COMM_ADDR_LSB  = 4;

  typedef logic [N_WORDS-1:0][WORD_W-1:0] hold_t;

endpackage

// File: rtl/sampler_drain_ctrl_serializer.sv
// Holds one captured sample and presents it as five host words on a
// valid/ready stream, pulsing done_o as the last word is accepted.
module sampler_word_serializer
  import sampler_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  hold_t             data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o,
  output logic              done_o
);

  hold_t      hold_q, hold_d;
  logic [2:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;

  always_comb begin
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_o  = 1'b0;
    if (load_i) begin
      hold_d  = data_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      if (cnt_q == 3'(N_WORDS - 1)) begin
        valid_d = 1'b0;
        done_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = hold_q[cnt_q];

endmodule

// File: rtl/sampler_drain_ctrl.sv
// Sequences the lease sampler: run until full or stopped, drain the buffer
// to the host word stream, clear, and resume or finish after a table dump.
module sampler_drain_ctrl
  import sampler_pkg::*;
#(
  parameter int unsigned BUF_AW  = 13,
  parameter int unsigned N_TABLE = 64,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              smp_full_i,
  input  logic [31:0]       smp_used_i,
  input  logic [31:0]       smp_interval_i,
  input  logic [31:0]       smp_pc_i,
  input  logic [63:0]       smp_trace_i,
  input  logic [31:0]       smp_target_i,
  output logic              smp_run_o,
  output logic              smp_clear_o,
  output logic              smp_dump_o,
  output logic [BUF_AW-1:0] rd_addr_o,
  output logic [31:0]       out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic [15:0]       drains_o
);

  localparam logic [BUF_AW:0] DEPTH    = (BUF_AW + 1)'(1) << BUF_AW;
  localparam logic [BUF_AW:0] USED_ONE = (BUF_AW + 1)'(1);

  state_e            state_q, state_d;
  logic              final_q, final_d;
  logic              stop_pend_q, stop_pend_d;
  logic [BUF_AW:0]   used_q, used_d;
  logic [BUF_AW-1:0] idx_q, idx_d;
  logic [15:0]       wait_q, wait_d;
  logic [15:0]       drains_q, drains_d;
  logic              run_q, run_d, clear_q, clear_d, dump_q, dump_d, busy_q, busy_d;

  logic [BUF_AW:0]   used_clamped;
  logic [31:0]       hdr_word;
  hold_t             hold_in;
  logic              ser_load, ser_valid, ser_done;
  logic [31:0]       ser_data;

  always_comb begin
    used_clamped = (smp_used_i > 32'(DEPTH)) ? DEPTH : smp_used_i[BUF_AW:0];
    hdr_word                  = '0;
    hdr_word[HDR_USED_W-1:0]  = HDR_USED_W'(used_q);
    hdr_word[HDR_FINAL_BIT]   = final_q;
    hold_in                   = '0;
    hold_in[W_INTERVAL]       = smp_interval_i;
    hold_in[W_PC]             = smp_pc_i;
    hold_in[W_TRACE_LO]       = smp_trace_i[31:0];
    hold_in[W_TRACE_HI]       = smp_trace_i[63:32];
    hold_in[W_TARGET]         = smp_target_i;
  end

  always_comb begin
    state_d     = state_q;
    final_d     = final_q;
    stop_pend_d = stop_pend_q;
    used_d      = used_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    drains_d    = drains_q;
    ser_load    = 1'b0;

    // A stop arriving mid-drain is held and serviced once the buffer is cleared
    if (stop_i && !final_q && (state_q inside {S_HDR, S_READ, S_WAIT, S_EMIT, S_CLEAR}))
      stop_pend_d = 1'b1;

    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (smp_full_i) begin
          state_d     = S_HDR;
          used_d      = used_clamped;
          stop_pend_d = stop_pend_q | stop_i;
        end else if (stop_i || stop_pend_q) begin
          state_d     = S_DUMP;
          stop_pend_d = 1'b0;
        end
      end
      S_DUMP: begin
        state_d = S_DUMP_WAIT;
        wait_d  = 16'(N_TABLE + 1);
      end
      S_DUMP_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_HDR;
          final_d = 1'b1;
          used_d  = used_clamped;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      S_HDR: begin
        if (out_ready_i) begin
          if (used_q == '0) begin
            state_d = S_CLEAR;
          end else begin
            state_d = S_READ;
            idx_d   = '0;
          end
        end
      end
      S_READ: begin
        state_d = S_WAIT;
        wait_d  = 16'(RD_LAT);
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          ser_load = 1'b1;
          state_d  = S_EMIT;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      S_EMIT: begin
        if (ser_done) begin
          if ({1'b0, idx_q} == used_q - USED_ONE) begin
            state_d = S_CLEAR;
          end else begin
            state_d = S_READ;
            idx_d   = idx_q + BUF_AW'(1);
          end
        end
      end
      S_CLEAR: begin
        idx_d = '0;
        if (final_q) begin
          state_d = S_DONE;
        end else if (stop_pend_q || stop_i) begin
          state_d     = S_DUMP;
          stop_pend_d = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (start_i) begin
          state_d     = S_RUN;
          final_d     = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_CLEAR && drains_q != 16'hFFFF) drains_d = drains_q + 16'd1;

    run_d   = (state_d == S_RUN);
    clear_d = (state_d == S_CLEAR);
    dump_d  = (state_d == S_DUMP);
    busy_d  = !(state_d inside {S_IDLE, S_DONE});
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      final_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      used_q      <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      drains_q    <= '0;
      run_q       <= 1'b0;
      clear_q     <= 1'b0;
      dump_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      final_q     <= final_d;
      stop_pend_q <= stop_pend_d;
      used_q      <= used_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      drains_q    <= drains_d;
      run_q       <= run_d;
      clear_q     <= clear_d;
      dump_q      <= dump_d;
      busy_q      <= busy_d;
    end
  end

  sampler_word_serializer u_ser (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .load_i  (ser_load),
    .data_i  (hold_in),
    .ready_i (out_ready_i),
    .valid_o (ser_valid),
    .data_o  (ser_data),
    .done_o  (ser_done)
  );

  always_comb begin
    out_valid_o = (state_q == S_HDR) || ser_valid;
    if (state_q == S_HDR) out_data_o = hdr_word;
    else if (ser_valid)   out_data_o = ser_data;
    else                  out_data_o = '0;
  end

  assign smp_run_o   = run_q;
  assign smp_clear_o = clear_q;
  assign smp_dump_o  = dump_q;
  assign rd_addr_o   = idx_q;
  assign busy_o      = busy_q;
  assign drains_o    = drains_q;

endmodule

// File: tb/tb_sampler_drain_ctrl.sv
// Scoreboard bench for sampler_drain_ctrl: stimulus queues expected host words,
// a negedge monitor pops and compares every accepted word.
module tb_sampler_drain_ctrl;

  localparam int unsigned BUF_AW  = 13;
  localparam int unsigned N_TABLE = 64;
  localparam int unsigned RD_LAT  = 2;

  logic              clock_i = 1'b0;
  logic              reset_i, start_i, stop_i, smp_full_i, out_ready_i;
  logic [31:0]       smp_used_i, smp_interval_i, smp_pc_i, smp_target_i;
  logic [63:0]       smp_trace_i;
  logic              smp_run_o, smp_clear_o, smp_dump_o, out_valid_o, busy_o;
  logic [BUF_AW-1:0] rd_addr_o;
  logic [31:0]       out_data_o;
  logic [15:0]       drains_o;

  always #5 clock_i = ~clock_i;

  sampler_drain_ctrl #(.BUF_AW(BUF_AW), .N_TABLE(N_TABLE), .RD_LAT(RD_LAT)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
    .smp_full_i(smp_full_i), .smp_used_i(smp_used_i), .smp_interval_i(smp_interval_i),
    .smp_pc_i(smp_pc_i), .smp_trace_i(smp_trace_i), .smp_target_i(smp_target_i),
    .smp_run_o(smp_run_o), .smp_clear_o(smp_clear_o), .smp_dump_o(smp_dump_o),
    .rd_addr_o(rd_addr_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .drains_o(drains_o)
  );

  // Sampler buffer model: data follows the read address after two clocks
  logic [BUF_AW-1:0] a1 = '0, a2 = '0;
  always @(posedge clock_i) begin
    a1 <= rd_addr_o;
    a2 <= a1;
  end
  always_comb begin
    smp_interval_i = 32'h1000_0000 + 32'(a2);
    smp_pc_i       = 32'h2000_0000 + 32'(a2);
    smp_trace_i    = {32'h3300_0000 + 32'(a2), 32'h3000_0000 + 32'(a2)};
    smp_target_i   = 32'h4000_0000 + 32'(a2);
  end

  int unsigned checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  int unsigned acc_cnt = 0, clr_cnt = 0, dump_cnt = 0;
  logic        stall_pend = 1'b0;
  logic [31:0] stall_data = '0;
  logic        rd_nz = 1'b0;
  int unsigned rdy_mode = 0, rcyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int unsigned a, input int unsigned k);
    case (k)
      0:       return 32'h1000_0000 + a;
      1:       return 32'h2000_0000 + a;
      2:       return 32'h3000_0000 + a;
      3:       return 32'h3300_0000 + a;
      default: return 32'h4000_0000 + a;
    endcase
  endfunction

  always @(negedge clock_i) begin
    if (smp_clear_o) clr_cnt++;
    if (smp_dump_o) dump_cnt++;
    if (stall_pend && out_valid_o) check("stall_hold", out_data_o, stall_data);
    if (out_valid_o && out_ready_i) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_word: got %08h with no word expected", out_data_o);
      end else begin
        check("word", out_data_o, exp_q.pop_front());
      end
    end
    stall_pend = out_valid_o && !out_ready_i;
    stall_data = out_data_o;
  end

  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clock_i);
      #1;
      rcyc++;
      out_ready_i = (rdy_mode == 0) || (rcyc % 3 == 0);
    end
  end

  task automatic push_drain(input logic fin, input int unsigned used);
    exp_q.push_back({fin, 15'b0, 16'(used)});
    for (int unsigned a = 0; a < used; a++)
      for (int unsigned k = 0; k < 5; k++) exp_q.push_back(exp_word(a, k));
  endtask

  task automatic pulse_full(input logic with_stop);
    @(negedge clock_i);
    smp_full_i = 1'b1;
    stop_i     = with_stop;
    @(negedge clock_i);
    smp_full_i = 1'b0;
    stop_i     = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clock_i);
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int unsigned limit);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clock_i);
      n++;
      if (rd_addr_o != '0) rd_nz = 1'b1;
    end
    while (!(smp_run_o || !busy_o) && n < limit) begin
      @(negedge clock_i);
      n++;
    end
    checks++;
    if (n >= limit) begin
      failures++;
      $display("FAIL %s_timeout: %0d words pending after %0d cycles", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, d0, a0, n, extra_dump, extra_run;
    reset_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; smp_full_i = 1'b0; smp_used_i = '0;
    repeat (3) @(negedge clock_i);
    check("rst_run", smp_run_o, 0);
    check("rst_clear", smp_clear_o, 0);
    check("rst_dump", smp_dump_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_addr", rd_addr_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_drains", drains_o, 0);
    reset_i = 1'b0;

    // stop in IDLE is ignored
    @(negedge clock_i); stop_i = 1'b1;
    @(negedge clock_i); stop_i = 1'b0;
    check("idle_stop_ignored", busy_o, 0);

    do_start();
    check("start_run", smp_run_o, 1);
    check("start_busy", busy_o, 1);

    // Full with three stored samples
    smp_used_i = 3; push_drain(1'b0, 3); c0 = clr_cnt;
    pulse_full(1'b0);
    wait_drained("drain3", 400);
    check("drain3_clears", clr_cnt - c0, 1);
    check("drain3_drains", drains_o, 1);
    check("drain3_run", smp_run_o, 1);

    // Host ready only one cycle in three
    rdy_mode = 1;
    smp_used_i = 2; push_drain(1'b0, 2);
    pulse_full(1'b0);
    wait_drained("stall2", 600);
    check("stall2_drains", drains_o, 2);
    rdy_mode = 0;

    // Empty buffer: header only
    smp_used_i = 0; push_drain(1'b0, 0); c0 = clr_cnt; rd_nz = 1'b0;
    pulse_full(1'b0);
    wait_drained("empty", 200);
    check("empty_addr_stays0", rd_nz, 0);
    check("empty_clears", clr_cnt - c0, 1);
    check("empty_drains", drains_o, 3);
    check("empty_run", smp_run_o, 1);

    // Stop and full together: normal drain, then dump and final drain
    smp_used_i = 1; push_drain(1'b0, 1); push_drain(1'b1, 1);
    c0 = clr_cnt; d0 = dump_cnt;
    pulse_full(1'b1);
    wait_drained("stopfull", 800);
    check("stopfull_drains", drains_o, 5);
    check("stopfull_dumps", dump_cnt - d0, 1);
    check("stopfull_clears", clr_cnt - c0, 2);
    check("stopfull_busy", busy_o, 0);
    check("stopfull_run", smp_run_o, 0);

    // Plain stop from RUN
    do_start();
    check("restart_run", smp_run_o, 1);
    smp_used_i = 2; push_drain(1'b1, 2); c0 = clr_cnt;
    @(negedge clock_i); stop_i = 1'b1;
    @(negedge clock_i); stop_i = 1'b0;
    check("stop_dump_pulse", smp_dump_o, 1);
    check("stop_run_low", smp_run_o, 0);
    n = 0; extra_dump = 0; extra_run = 0;
    @(negedge clock_i);
    while (!out_valid_o && n < 200) begin
      n++;
      if (smp_dump_o) extra_dump++;
      if (smp_run_o) extra_run++;
      @(negedge clock_i);
    end
    check("dump_wait_cycles", n, N_TABLE + 2);
    check("dump_one_cycle", extra_dump, 0);
    check("run_low_in_wait", extra_run, 0);
    wait_drained("stop2", 400);
    check("stop2_busy", busy_o, 0);
    check("stop2_run", smp_run_o, 0);
    check("stop2_drains", drains_o, 6);
    check("stop2_clears", clr_cnt - c0, 1);

    // Reset while the third data word is on the bus
    do_start();
    smp_used_i = 1; push_drain(1'b0, 1); a0 = acc_cnt;
    pulse_full(1'b0);
    n = 0;
    while (acc_cnt < a0 + 3 && n < 100) begin
      @(posedge clock_i);
      #1;
      n++;
    end
    #1;
    check("third_word_valid", out_valid_o, 1);
    check("third_word_data", out_data_o, 32'h3000_0000);
    reset_i = 1'b1;
    #1;
    check("midrst_valid", out_valid_o, 0);
    check("midrst_data", out_data_o, 0);
    check("midrst_run", smp_run_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_drains", drains_o, 0);
    check("midrst_addr", rd_addr_o, 0);
    exp_q.delete();
    @(negedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    do_start();
    check("post_rst_run", smp_run_o, 1);
    smp_used_i = 1; push_drain(1'b0, 1);
    pulse_full(1'b0);
    wait_drained("post_rst", 300);
    check("post_rst_drains", drains_o, 1);
    check("post_rst_run_again", smp_run_o, 1);

    repeat (3) @(negedge clock_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
